// File: rtl/mpt_pkg.sv
// Shared MPT walker flush types: stage ctrl/status encodings and the flush
// controller FSM states.
package mpt_pkg;

    typedef enum logic [1:0] {
        MPT_FLUSH_NONE    = 2'd0,
        MPT_FLUSH_REQUEST = 2'd1
    } mptw_flush_ctrl_e;

    typedef enum logic [1:0] {
        MPT_FLUSHED_NONE      = 2'd0,
        MPT_FLUSHED_ONGOING   = 2'd1,
        MPT_FLUSHED_COMPLETED = 2'd2
    } mptw_flush_status_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } mptw_flush_fsm_e;

    localparam int MPT_FLUSH_TIMEOUT_DEFAULT = 1024;
    localparam int MPT_FLUSH_CTRL_W          = $bits(mptw_flush_ctrl_e);
    localparam int MPT_FLUSH_STATUS_W        = $bits(mptw_flush_status_e);

endpackage

// File: rtl/mptw_prio_encoder.sv
// Highest-set-bit finder: one-hot of the most significant request bit plus a
// valid flag when any bit is set.
module mptw_prio_encoder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] onehot,
    output logic             valid
);

    logic found_s;

    // Scan from the top so only the highest set bit survives.
    always_comb begin
        found_s = 1'b0;
        onehot  = {WIDTH{1'b0}};
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i] && !found_s) begin
                onehot[i] = 1'b1;
                found_s   = 1'b1;
            end else begin
                onehot[i] = 1'b0;
            end
        end
        valid = found_s;
    end

endmodule

// File: rtl/mptw_flush_controller.sv
// Fans a flush request out to the selected walker stages (broadcast or
// back-to-front), waits for each stage to report completion with a timeout.
module mptw_flush_controller
    import mpt_pkg::*;
#(
    parameter int NUM_STAGES     = 4,
    parameter bit SEQUENTIAL     = 1'b1,
    parameter int TIMEOUT_CYCLES = MPT_FLUSH_TIMEOUT_DEFAULT
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic                                     flush_req_i,
    input  logic [NUM_STAGES-1:0]                    flush_mask_i,
    output logic                                     flush_ready_o,
    output logic                                     flush_done_o,
    output logic                                     flush_timeout_o,
    output logic                                     stall_o,
    output logic [NUM_STAGES*MPT_FLUSH_CTRL_W-1:0]   stage_ctrl_flush_o,
    input  logic [NUM_STAGES*MPT_FLUSH_STATUS_W-1:0] stage_status_flushed_i
);

    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mptw_flush_fsm_e                      state_r, state_s;
    logic [NUM_STAGES-1:0]                pend_r, pend_s;
    logic [NUM_STAGES-1:0]                tgt_r, tgt_s;
    logic                                 to_r, to_s;
    logic [CNT_W-1:0]                     cnt_r, cnt_s;
    logic [NUM_STAGES-1:0]                stage_ok_s;
    logic                                 step_complete_s;
    logic                                 step_end_s;
    logic [NUM_STAGES-1:0]                enc_onehot_s;
    logic                                 enc_valid_s;
    logic [NUM_STAGES*MPT_FLUSH_CTRL_W-1:0] ctrl_s, ctrl_r;
    logic                                 done_r, timeout_r, stall_r;

    // Sequential target is chosen from the pending set as it will be next cycle,
    // so the registered ctrl moves to the next stage without a gap.
    mptw_prio_encoder #(
        .WIDTH (NUM_STAGES)
    ) u_prio (
        .req    (pend_s),
        .onehot (enc_onehot_s),
        .valid  (enc_valid_s)
    );

    // Step completion: every current target reports COMPLETED; others ignored.
    always_comb begin
        for (int i = 0; i < NUM_STAGES; i++) begin
            stage_ok_s[i] = !tgt_r[i] ||
                (stage_status_flushed_i[i*MPT_FLUSH_STATUS_W +: MPT_FLUSH_STATUS_W]
                 == MPT_FLUSHED_COMPLETED);
        end
        step_complete_s = &stage_ok_s;
        step_end_s      = step_complete_s || (cnt_r == CNT_LAST);
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and datapath next values.
    always_comb begin
        state_s = state_r;
        pend_s  = pend_r;
        to_s    = to_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (flush_req_i) begin
                    pend_s  = flush_mask_i;
                    to_s    = 1'b0;
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = (|flush_mask_i) ? FLUSH : DONE;
                end else begin
                    state_s = IDLE;
                end
            end
            FLUSH: begin
                if (step_end_s) begin
                    to_s    = to_r | !step_complete_s;
                    pend_s  = pend_r & ~tgt_r;
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = (|(pend_r & ~tgt_r)) ? FLUSH : DONE;
                end else begin
                    cnt_s   = cnt_r + CNT_W'(1);
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Target set and per-stage ctrl encoding for the coming cycle.
    always_comb begin
        if (state_s == FLUSH) begin
            if (SEQUENTIAL) begin
                tgt_s = enc_valid_s ? enc_onehot_s : {NUM_STAGES{1'b0}};
            end else begin
                tgt_s = pend_s;
            end
        end else begin
            tgt_s = {NUM_STAGES{1'b0}};
        end
        for (int i = 0; i < NUM_STAGES; i++) begin
            ctrl_s[i*MPT_FLUSH_CTRL_W +: MPT_FLUSH_CTRL_W] =
                tgt_s[i] ? MPT_FLUSH_REQUEST : MPT_FLUSH_NONE;
        end
    end

    // Pending set, current targets, timeout flag and step counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_r <= {NUM_STAGES{1'b0}};
            tgt_r  <= {NUM_STAGES{1'b0}};
            to_r   <= 1'b0;
            cnt_r  <= {CNT_W{1'b0}};
        end else begin
            pend_r <= pend_s;
            tgt_r  <= tgt_s;
            to_r   <= to_s;
            cnt_r  <= cnt_s;
        end
    end

    // Registered outputs, loaded from the next state so they align with it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl_r    <= {(NUM_STAGES*MPT_FLUSH_CTRL_W){1'b0}};
            done_r    <= 1'b0;
            timeout_r <= 1'b0;
            stall_r   <= 1'b0;
        end else begin
            ctrl_r    <= ctrl_s;
            done_r    <= (state_s == DONE);
            timeout_r <= (state_s == DONE) && to_s;
            stall_r   <= (state_s != IDLE);
        end
    end

    // Output drive; ready depends only on the current state.
    always_comb begin
        flush_ready_o      = (state_r == IDLE);
        flush_done_o       = done_r;
        flush_timeout_o    = timeout_r;
        stall_o            = stall_r;
        stage_ctrl_flush_o = ctrl_r;
    end

endmodule
